// File: rtl/saturation_reg.sv
// Registered signed clamp from N to K bits, with per-sample overflow flags
// and a saturating count of clamped samples.
module saturation_reg #(
  parameter int N     = 5,
  parameter int K     = 3,
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rstn,
  input  logic             i_valid,
  input  logic [N-1:0]     i_data,
  input  logic             i_clr,
  output logic             o_valid,
  output logic [K-1:0]     o_data,
  output logic             o_sat_pos,
  output logic             o_sat_neg,
  output logic [CNT_W-1:0] o_sat_cnt
);

  // Bounds expressed at input width for the compare, and at output width for the result.
  localparam logic signed [N-1:0] MAX_N = {{(N-K+1){1'b0}}, {(K-1){1'b1}}};
  localparam logic signed [N-1:0] MIN_N = {{(N-K+1){1'b1}}, {(K-1){1'b0}}};
  localparam logic signed [K-1:0] MAX_K = {1'b0, {(K-1){1'b1}}};
  localparam logic signed [K-1:0] MIN_K = {1'b1, {(K-1){1'b0}}};

  // Result packing: {sat_pos, sat_neg, data[K-1:0]}
  function automatic logic [K+1:0] sat_clamp(input logic signed [N-1:0] x);
    logic [K+1:0] r;
    if (x > MAX_N)      r = {1'b1, 1'b0, MAX_K};
    else if (x < MIN_N) r = {1'b0, 1'b1, MIN_K};
    else                r = {1'b0, 1'b0, x[K-1:0]};
    return r;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == {CNT_W{1'b1}}) ? c : c + CNT_W'(1);
  endfunction

  logic signed [N-1:0] data_p0;
  logic [K+1:0]        clamp_p0;
  logic                pos_p0;
  logic                neg_p0;

  logic                vld_p1;
  logic signed [K-1:0] data_p1;
  logic                pos_p1;
  logic                neg_p1;
  logic [CNT_W-1:0]    cnt_p1;

  always_comb begin
    data_p0  = i_data;
    clamp_p0 = sat_clamp(data_p0);
    pos_p0   = clamp_p0[K+1];
    neg_p0   = clamp_p0[K];
  end

  // ---- p0 -> p1: register clamp result, flags and event counter ----
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
      pos_p1  <= 1'b0;
      neg_p1  <= 1'b0;
      cnt_p1  <= '0;
    end else begin
      vld_p1 <= i_valid;
      pos_p1 <= i_valid & pos_p0;
      neg_p1 <= i_valid & neg_p0;
      if (i_valid)
        data_p1 <= clamp_p0[K-1:0];
      if (i_clr)
        cnt_p1 <= '0;
      else if (i_valid && (pos_p0 || neg_p0))
        cnt_p1 <= sat_inc(cnt_p1);
    end
  end

  assign o_valid   = vld_p1;
  assign o_data    = data_p1;
  assign o_sat_pos = pos_p1;
  assign o_sat_neg = neg_p1;
  assign o_sat_cnt = cnt_p1;

endmodule

// File: tb/tb_saturation_reg.sv
// Directed bench for saturation_reg (N=5, K=3): sweeps, latency, clear,
// counter ceiling (second instance with CNT_W=2) and async reset.
module tb_saturation_reg;

  logic        clk = 1'b0;
  logic        rstn;
  logic        valid;
  logic [4:0]  data;
  logic        clr;

  logic        o_valid, o_pos, o_neg;
  logic [2:0]  o_data;
  logic [15:0] o_cnt;

  logic        o2_valid, o2_pos, o2_neg;
  logic [2:0]  o2_data;
  logic [1:0]  o2_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  saturation_reg #(.N(5), .K(3), .CNT_W(16)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_data(data), .i_clr(clr),
    .o_valid(o_valid), .o_data(o_data), .o_sat_pos(o_pos), .o_sat_neg(o_neg),
    .o_sat_cnt(o_cnt)
  );

  saturation_reg #(.N(5), .K(3), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_rstn(rstn), .i_valid(valid), .i_data(data), .i_clr(clr),
    .o_valid(o2_valid), .o_data(o2_data), .o_sat_pos(o2_pos), .o_sat_neg(o2_neg),
    .o_sat_cnt(o2_cnt)
  );

  task automatic check(input string tag, input int got, input int exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input int d, input logic c);
    valid = v;
    data  = 5'(d);
    clr   = c;
  endtask

  task automatic check_out(input string tag, input int d, input int p, input int n, input int c);
    check({tag, ".valid"}, int'(o_valid), 1);
    check({tag, ".data"},  int'($signed(o_data)), d);
    check({tag, ".pos"},   int'(o_pos), p);
    check({tag, ".neg"},   int'(o_neg), n);
    check({tag, ".cnt"},   int'(o_cnt), c);
  endtask

  initial begin
    int cnt;
    rstn = 1'b1;
    drive(1'b0, 0, 1'b0);
    #1 rstn = 1'b0;
    #1;
    check("rst.valid", int'(o_valid), 0);
    check("rst.data",  int'(o_data), 0);
    check("rst.flags", int'({o_pos, o_neg}), 0);
    check("rst.cnt",   int'(o_cnt), 0);
    tick();
    tick();
    rstn = 1'b1;

    // Positive sweep
    cnt = 0;
    for (int v = 0; v <= 3; v++) begin
      drive(1'b1, v, 1'b0);
      tick();
      check_out("pos_in", v, 0, 0, cnt);
    end
    for (int v = 4; v <= 15; v++) begin
      drive(1'b1, v, 1'b0);
      tick();
      cnt++;
      check_out("pos_sat", 3, 1, 0, cnt);
    end
    check("pos_sweep.cnt12", int'(o_cnt), 12);

    // Negative sweep, ending at the most negative input -16
    for (int v = -1; v >= -4; v--) begin
      drive(1'b1, v, 1'b0);
      tick();
      check_out("neg_in", v, 0, 0, cnt);
    end
    for (int v = -5; v >= -16; v--) begin
      drive(1'b1, v, 1'b0);
      tick();
      cnt++;
      check_out("neg_sat", -4, 0, 1, cnt);
    end
    check("neg_sweep.cnt24", int'(o_cnt), 24);

    // Single valid pulse: latency 1, then data holds and flags drop
    drive(1'b0, 0, 1'b0);
    tick();
    check("idle.valid", int'(o_valid), 0);
    drive(1'b1, 7, 1'b0);
    tick();
    cnt++;
    check_out("pulse", 3, 1, 0, cnt);
    drive(1'b0, -9, 1'b0);
    tick();
    check("after.valid", int'(o_valid), 0);
    check("after.flags", int'({o_pos, o_neg}), 0);
    check("after.data",  int'($signed(o_data)), 3);
    check("after.cnt",   int'(o_cnt), cnt);

    // Counter clear with priority over a simultaneous saturating sample
    drive(1'b0, 0, 1'b1);
    tick();
    check("clr.cnt", int'(o_cnt), 0);
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 10, 1'b0);
      tick();
      check("clr_fill.cnt", int'(o_cnt), i);
    end
    drive(1'b1, -9, 1'b1);
    tick();
    check_out("clr_sat", -4, 0, 1, 0);
    drive(1'b1, 12, 1'b0);
    tick();
    check_out("clr_next", 3, 1, 0, 1);

    // Counter ceiling on the CNT_W=2 instance
    drive(1'b0, 0, 1'b1);
    tick();
    check("ceil.clr", int'(o2_cnt), 0);
    for (int i = 1; i <= 6; i++) begin
      drive(1'b1, (i % 2) ? 9 : -12, 1'b0);
      tick();
      check("ceil.cnt", int'(o2_cnt), (i < 3) ? i : 3);
      check("ceil.wide_cnt", int'(o_cnt), i);
    end
    check("ceil.flags", int'({o2_pos, o2_neg}), 2'b01);

    // Async reset mid-cycle with o_data=3, cnt=4
    drive(1'b0, 0, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 8, 1'b0);
      tick();
    end
    check("pre_rst.data", int'($signed(o_data)), 3);
    check("pre_rst.cnt",  int'(o_cnt), 4);
    drive(1'b1, 13, 1'b0);
    #2 rstn = 1'b0;
    #1;
    check("arst.valid", int'(o_valid), 0);
    check("arst.data",  int'(o_data), 0);
    check("arst.pos",   int'(o_pos), 0);
    check("arst.neg",   int'(o_neg), 0);
    check("arst.cnt",   int'(o_cnt), 0);
    tick();
    check("arst_hold.data", int'(o_data), 0);
    rstn = 1'b1;
    drive(1'b1, 2, 1'b0);
    tick();
    check_out("post_rst", 2, 0, 0, 0);
    drive(1'b0, 0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish, expected finish before 50000");
    $fatal(1);
  end

endmodule

// File: doc/saturation_reg.md
Name: saturation_reg

Overview:
- Registered signed saturation (clamp) stage: narrows a signed N-bit two's-complement sample to K bits.
- Clamps to the K-bit signed range instead of truncating.
- Sits at datapath width-reduction points, e.g. after accumulators or filters, ahead of narrower stages.
- Also reports per-sample overflow direction and keeps a running count of saturation events.

Parameters:
- N, 5, input width in bits, signed; must satisfy N >= K >= 2.
- K, 3, output width in bits, signed.
- CNT_W, 16, width of the saturation-event counter.

Ports:
- i_clk  input  1  system clock, rising-edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_valid  input  1  i_data is valid this cycle.
- i_data  input  N  signed two's-complement input sample.
- i_clr  input  1  synchronous clear of the event counter.
- o_valid  output  1  o_data is valid; i_valid delayed one cycle.
- o_data  output  K  signed saturated output.
- o_sat_pos  output  1  registered sample was clamped to MAX.
- o_sat_neg  output  1  registered sample was clamped to MIN.
- o_sat_cnt  output  CNT_W  number of saturated valid samples since reset or clear.

Behaviour:
- Bounds: MAX = 2^(K-1)-1 and MIN = -2^(K-1). Defaults give MAX = 3, MIN = -4.
- Clamp function, evaluated on signed i_data:
  - i_data > MAX -> MAX, sat_pos = 1.
  - i_data < MIN -> MIN, sat_neg = 1.
  - otherwise -> lower K bits of i_data, both flags 0.
- Implementation is free: full signed compare, or the equivalent check that bits [N-1:K-1] are all equal.
- N == K: pure pass-through; flags are always 0 and the counter never increments.
- Timing:
  - All outputs are registered on the rising edge of i_clk; latency is exactly 1 cycle.
  - A new sample is accepted every cycle; there is no backpressure.
- Valid handling:
  - o_valid <= i_valid.
  - When i_valid = 1: o_data, o_sat_pos and o_sat_neg load the clamp result.
  - When i_valid = 0: o_data holds its previous value, and o_sat_pos / o_sat_neg are forced to 0.
  - o_sat_pos and o_sat_neg are never both 1.
- Counter:
  - o_sat_cnt increments by 1 on each cycle with i_valid = 1 and (sat_pos or sat_neg).
  - It saturates at 2^CNT_W-1 and never wraps.
  - i_clr = 1 sets the counter to 0 on that edge; i_clr has priority over a simultaneous increment.
  - i_clr does not affect the data path.
- Reset:
  - i_rstn = 0 immediately (asynchronously) drives o_data = 0, o_valid = 0, o_sat_pos = 0, o_sat_neg = 0, o_sat_cnt = 0.
  - Release is sampled synchronously; the first sample is captured on the first rising edge with i_rstn = 1.
  - Reset asserted mid-stream discards the in-flight sample.
- Sign handling: all comparisons are signed; the most negative input (-2^(N-1)) maps to MIN with no overflow artefact.

Test Plan:
- Positive sweep (N=5, K=3), i_valid = 1, i_data = 0,1,2,3 -> o_data = 0,1,2,3, flags 0. Then i_data = 4..15 -> o_data = 3, o_sat_pos = 1 each cycle, o_sat_cnt increments to 12.
- Negative sweep: i_data = -1,-2,-3,-4 -> o_data = same values, flags 0. Then i_data = -5..-16 -> o_data = -4 (3'b100), o_sat_neg = 1; -16 (5'b10000) -> -4.
- Latency/valid: pulse i_valid for one cycle with i_data = 7 -> exactly one cycle later o_valid = 1, o_data = 3, o_sat_pos = 1. Next cycle o_valid = 0, flags 0, o_data stays 3.
- Counter clear: after 5 saturating samples (o_sat_cnt = 5), assert i_clr together with a saturating valid sample -> o_sat_cnt = 0. Next saturating sample -> 1.
- Counter ceiling: CNT_W = 2, 6 consecutive saturating samples -> o_sat_cnt = 1,2,3,3,3,3.
- Async reset: assert i_rstn = 0 between clock edges while o_data = 3, o_sat_cnt = 4 -> all outputs 0 immediately, before the next edge. Deassert, then i_data = 2 valid -> o_data = 2 one cycle later.
